// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b types for the MEM stage: data word, memory-op encoding,
// the barrier control word and the MEM sequencer state encoding.
package mem_stage_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LDW  = 3'd1,
        MEM_LDB  = 3'd2,
        MEM_STW  = 3'd3,
        MEM_STB  = 3'd4,
        MEM_LDI  = 3'd5,
        MEM_STI  = 3'd6
    } lc3b_mem_op;

    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        lc3b_mem_op mem_op;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_INDIRECT = 2'd2,
        ST_DONE     = 2'd3
    } mem_state_e;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_NONE = 2'b00;

    // Ops whose result lands in the MDR.
    function automatic logic is_load(input lc3b_mem_op op);
        return (op == MEM_LDW) || (op == MEM_LDB) || (op == MEM_LDI);
    endfunction

    // Ops that need a pointer fetch before the real access.
    function automatic logic is_indirect(input lc3b_mem_op op);
        return (op == MEM_LDI) || (op == MEM_STI);
    endfunction

    // Ops whose first access is a write.
    function automatic logic is_direct_write(input lc3b_mem_op op);
        return (op == MEM_STW) || (op == MEM_STB);
    endfunction

    // The d-cache is word addressed; drop the byte select bit.
    function automatic lc3b_word word_align(input lc3b_word a);
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Byte-lane steering for the MEM stage: store data replication and write
// enables, plus load byte extraction with sign extension.
module mem_byte_lane
    import mem_stage_ctrl_pkg::*;
(
    input  lc3b_mem_op  op_i,
    input  logic        addr_lsb_i,
    input  lc3b_word    wdata_src_i,
    input  lc3b_word    rdata_i,
    output lc3b_word    wdata_o,
    output logic [1:0]  byte_enable_o,
    output lc3b_word    load_data_o
);

    logic [7:0] load_byte;

    // Store path: byte stores replicate the low byte and enable one lane.
    always_comb begin
        wdata_o       = wdata_src_i;
        byte_enable_o = BE_WORD;
        if (op_i == MEM_STB) begin
            wdata_o       = {wdata_src_i[7:0], wdata_src_i[7:0]};
            byte_enable_o = addr_lsb_i ? BE_HI : BE_LO;
        end
    end

    // Load path: byte loads pick the addressed half and sign-extend it.
    always_comb begin
        load_byte   = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
        load_data_o = rdata_i;
        if (op_i == MEM_LDB) begin
            load_data_o = {{8{load_byte[7]}}, load_byte};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: sequences d-cache accesses for the op held in the
// EX/MEM barrier, stalls the pipeline while an access is outstanding and
// registers the load result for the MEM/WB barrier.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  lc3b_mem_op  mem_op_in,
    input  lc3b_word    addr_in,
    input  lc3b_word    data_in,
    input  logic        ext_stall,
    input  logic        dmem_resp,
    input  lc3b_word    dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output lc3b_word    dmem_address,
    output lc3b_word    dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        mem_stall,
    output lc3b_word    mdr_out,
    output logic        mdr_valid
);

    mem_state_e state_q, state_d;
    lc3b_word   ptr_q, ptr_d;
    lc3b_word   mdr_q, mdr_d;
    logic       mdr_valid_q, mdr_valid_d;

    logic       active_op;
    logic       op_indirect;
    logic       op_load;
    logic       complete;
    lc3b_word   lane_wdata;
    logic [1:0] lane_be;
    lc3b_word   lane_load;

    assign active_op   = valid_in && (mem_op_in != MEM_NONE);
    assign op_indirect = is_indirect(mem_op_in);
    assign op_load     = is_load(mem_op_in);

    // Final response of the op: direct ops finish in ACCESS, LDI/STI in INDIRECT.
    assign complete = dmem_resp &&
                      (((state_q == ST_ACCESS) && !op_indirect) ||
                       (state_q == ST_INDIRECT));

    mem_byte_lane u_lane (
        .op_i          (mem_op_in),
        .addr_lsb_i    (addr_in[0]),
        .wdata_src_i   (data_in),
        .rdata_i       (dmem_rdata),
        .wdata_o       (lane_wdata),
        .byte_enable_o (lane_be),
        .load_data_o   (lane_load)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE parks a finished op until the frozen barrier moves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (active_op) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (dmem_resp) begin
                    if (op_indirect)    state_d = ST_INDIRECT;
                    else if (ext_stall) state_d = ST_DONE;
                    else                state_d = ST_IDLE;
                end
            end
            ST_INDIRECT: begin
                if (dmem_resp) state_d = ext_stall ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!ext_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: requests only in ACCESS/INDIRECT; stall drops on the final response.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = BE_NONE;
        mem_stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_stall = active_op;
            end
            ST_ACCESS: begin
                dmem_address = word_align(addr_in);
                if (is_direct_write(mem_op_in)) begin
                    dmem_write       = 1'b1;
                    dmem_wdata       = lane_wdata;
                    dmem_byte_enable = lane_be;
                end else begin
                    dmem_read        = 1'b1;
                    dmem_byte_enable = BE_WORD;
                end
                mem_stall = !dmem_resp || op_indirect;
            end
            ST_INDIRECT: begin
                dmem_address     = word_align(ptr_q);
                dmem_byte_enable = BE_WORD;
                if (mem_op_in == MEM_STI) begin
                    dmem_write = 1'b1;
                    dmem_wdata = data_in;
                end else begin
                    dmem_read  = 1'b1;
                end
                mem_stall = !dmem_resp;
            end
            default: begin
            end
        endcase
    end

    // Pointer capture on the first response of LDI/STI; MDR and its valid flag.
    always_comb begin
        ptr_d       = ptr_q;
        mdr_d       = mdr_q;
        mdr_valid_d = mdr_valid_q;
        if ((state_q == ST_ACCESS) && dmem_resp && op_indirect) begin
            ptr_d = dmem_rdata;
        end
        if (complete) begin
            mdr_valid_d = op_load;
            if (op_load) mdr_d = lane_load;
        end else if ((state_q == ST_IDLE) && !active_op && !ext_stall) begin
            mdr_valid_d = 1'b0;
        end
    end

    // Data registers clear on reset so a mid-access reset leaves nothing stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            mdr_q       <= '0;
            mdr_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            mdr_q       <= mdr_d;
            mdr_valid_q <= mdr_valid_d;
        end
    end

    assign mdr_out   = mdr_q;
    assign mdr_valid = mdr_valid_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    lc3b_mem_op  mem_op_in;
    lc3b_word    addr_in;
    lc3b_word    data_in;
    logic        ext_stall;
    logic        dmem_resp;
    lc3b_word    dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    lc3b_word    dmem_address;
    lc3b_word    dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        mem_stall;
    lc3b_word    mdr_out;
    logic        mdr_valid;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .mem_op_in        (mem_op_in),
        .addr_in          (addr_in),
        .data_in          (data_in),
        .ext_stall        (ext_stall),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_stall        (mem_stall),
        .mdr_out          (mdr_out),
        .mdr_valid        (mdr_valid)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and drive the barrier/cache inputs.
    task automatic step(input logic v, input lc3b_mem_op op, input lc3b_word a,
                        input lc3b_word d, input logic xs, input logic r,
                        input lc3b_word rd);
        @(negedge clk);
        valid_in   = v;
        mem_op_in  = op;
        addr_in    = a;
        data_in    = d;
        ext_stall  = xs;
        dmem_resp  = r;
        dmem_rdata = rd;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable} !== 35'h0) begin
            $display("FAIL reset_req got rd=%b wr=%b a=%h wd=%h be=%b want all 0",
                     dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable);
            n_bad++;
        end
        n_cmp++;
        if ({mem_stall, mdr_valid, mdr_out} !== 18'h0) begin
            $display("FAIL reset_mdr got stall=%b v=%b mdr=%h want 0", mem_stall, mdr_valid, mdr_out);
            n_bad++;
        end
        reset = 1'b0;
    endtask

    task automatic test_ldw();
        int stall_cnt = 0;
        step(1'b1, MEM_LDW, 16'h1235, 16'h0, 1'b0, 1'b0, 16'h0);
        stall_cnt += int'(mem_stall);
        n_cmp++;
        if (dmem_read !== 1'b0) begin
            $display("FAIL ldw_idle_noreq got %b want 0", dmem_read); n_bad++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, MEM_LDW, 16'h1235, 16'h0, 1'b0, 1'b0, 16'h0);
            stall_cnt += int'(mem_stall);
            n_cmp++;
            if ({dmem_read, dmem_write, dmem_address, dmem_byte_enable} !== {1'b1, 1'b0, 16'h1234, 2'b11}) begin
                $display("FAIL ldw_req cyc%0d got rd=%b wr=%b a=%h be=%b want rd=1 wr=0 a=1234 be=11",
                         i, dmem_read, dmem_write, dmem_address, dmem_byte_enable);
                n_bad++;
            end
        end
        step(1'b1, MEM_LDW, 16'h1235, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        n_cmp++;
        if (mem_stall !== 1'b0 || stall_cnt != 4) begin
            $display("FAIL ldw_stall got final=%b count=%0d want final=0 count=4", mem_stall, stall_cnt);
            n_bad++;
        end
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mdr_out !== 16'hBEEF || mdr_valid !== 1'b1 || dmem_read !== 1'b0) begin
            $display("FAIL ldw_mdr got mdr=%h v=%b rd=%b want BEEF 1 0", mdr_out, mdr_valid, dmem_read);
            n_bad++;
        end
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mdr_valid !== 1'b0 || mdr_out !== 16'hBEEF) begin
            $display("FAIL ldw_vclear got v=%b mdr=%h want 0 BEEF", mdr_valid, mdr_out);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back_ldb();
        step(1'b1, MEM_LDB, 16'h2001, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b1, MEM_LDB, 16'h2001, 16'h0, 1'b0, 1'b1, 16'h80AA);
        n_cmp++;
        if (dmem_address !== 16'h2000 || dmem_read !== 1'b1 || mem_stall !== 1'b0) begin
            $display("FAIL ldb_hi_req got a=%h rd=%b stall=%b want 2000 1 0", dmem_address, dmem_read, mem_stall);
            n_bad++;
        end
        step(1'b1, MEM_LDB, 16'h2000, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mdr_out !== 16'hFF80 || mdr_valid !== 1'b1 || mem_stall !== 1'b1) begin
            $display("FAIL ldb_hi got mdr=%h v=%b stall=%b want FF80 1 1", mdr_out, mdr_valid, mem_stall);
            n_bad++;
        end
        step(1'b1, MEM_LDB, 16'h2000, 16'h0, 1'b0, 1'b1, 16'h80AA);
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mdr_out !== 16'hFFAA || mdr_valid !== 1'b1) begin
            $display("FAIL ldb_lo got mdr=%h v=%b want FFAA 1", mdr_out, mdr_valid);
            n_bad++;
        end
    endtask

    task automatic test_stb();
        step(1'b1, MEM_STB, 16'h3003, 16'h0012, 1'b0, 1'b0, 16'h0);
        step(1'b1, MEM_STB, 16'h3003, 16'h0012, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if ({dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable, mem_stall}
            !== {1'b1, 1'b0, 16'h3002, 16'h1212, 2'b10, 1'b1}) begin
            $display("FAIL stb_req got wr=%b rd=%b a=%h wd=%h be=%b stall=%b want 1 0 3002 1212 10 1",
                     dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable, mem_stall);
            n_bad++;
        end
        step(1'b1, MEM_STB, 16'h3003, 16'h0012, 1'b0, 1'b1, 16'h0);
        n_cmp++;
        if (mem_stall !== 1'b0) begin
            $display("FAIL stb_done got stall=%b want 0", mem_stall); n_bad++;
        end
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (dmem_write !== 1'b0 || mdr_valid !== 1'b0) begin
            $display("FAIL stb_after got wr=%b v=%b want 0 0", dmem_write, mdr_valid); n_bad++;
        end
    endtask

    task automatic test_ldi();
        step(1'b1, MEM_LDI, 16'h4000, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b1, MEM_LDI, 16'h4000, 16'h0, 1'b0, 1'b1, 16'h5001);
        n_cmp++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h4000 || mem_stall !== 1'b1) begin
            $display("FAIL ldi_ptr got rd=%b a=%h stall=%b want 1 4000 1", dmem_read, dmem_address, mem_stall);
            n_bad++;
        end
        step(1'b1, MEM_LDI, 16'h4000, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h5000 || mem_stall !== 1'b1) begin
            $display("FAIL ldi_ind got rd=%b a=%h stall=%b want 1 5000 1", dmem_read, dmem_address, mem_stall);
            n_bad++;
        end
        step(1'b1, MEM_LDI, 16'h4000, 16'h0, 1'b0, 1'b1, 16'h7777);
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mdr_out !== 16'h7777 || mdr_valid !== 1'b1) begin
            $display("FAIL ldi_mdr got mdr=%h v=%b want 7777 1", mdr_out, mdr_valid); n_bad++;
        end
    endtask

    task automatic test_sti();
        step(1'b1, MEM_STI, 16'h4000, 16'h1357, 1'b0, 1'b0, 16'h0);
        step(1'b1, MEM_STI, 16'h4000, 16'h1357, 1'b0, 1'b1, 16'h6000);
        n_cmp++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0) begin
            $display("FAIL sti_ptr got rd=%b wr=%b want 1 0", dmem_read, dmem_write); n_bad++;
        end
        step(1'b1, MEM_STI, 16'h4000, 16'h1357, 1'b0, 1'b1, 16'h0);
        n_cmp++;
        if ({dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable, mem_stall}
            !== {1'b1, 1'b0, 16'h6000, 16'h1357, 2'b11, 1'b0}) begin
            $display("FAIL sti_wr got wr=%b rd=%b a=%h wd=%h be=%b stall=%b want 1 0 6000 1357 11 0",
                     dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable, mem_stall);
            n_bad++;
        end
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mdr_valid !== 1'b0 || dmem_write !== 1'b0) begin
            $display("FAIL sti_after got v=%b wr=%b want 0 0", mdr_valid, dmem_write); n_bad++;
        end
    endtask

    task automatic test_ext_stall_done();
        step(1'b1, MEM_LDW, 16'hFFFF, 16'h0, 1'b1, 1'b0, 16'h0);
        step(1'b1, MEM_LDW, 16'hFFFF, 16'h0, 1'b1, 1'b1, 16'h1111);
        n_cmp++;
        if (dmem_address !== 16'hFFFE || mem_stall !== 1'b0) begin
            $display("FAIL ldw_ffff got a=%h stall=%b want FFFE 0", dmem_address, mem_stall); n_bad++;
        end
        for (int i = 0; i < 2; i++) begin
            // a stray response while parked must not overwrite the MDR
            step(1'b1, MEM_LDW, 16'hFFFF, 16'h0, 1'b1, (i == 0), 16'h2222);
            n_cmp++;
            if ({dmem_read, dmem_write, mem_stall} !== 3'b000 || mdr_out !== 16'h1111 || mdr_valid !== 1'b1) begin
                $display("FAIL done_hold cyc%0d got rd=%b wr=%b stall=%b mdr=%h v=%b want 0 0 0 1111 1",
                         i, dmem_read, dmem_write, mem_stall, mdr_out, mdr_valid);
                n_bad++;
            end
        end
        step(1'b1, MEM_LDW, 16'hFFFF, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (dmem_read !== 1'b0 || mem_stall !== 1'b0) begin
            $display("FAIL done_release got rd=%b stall=%b want 0 0", dmem_read, mem_stall); n_bad++;
        end
        step(1'b1, MEM_LDW, 16'h0042, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (mem_stall !== 1'b1 || dmem_read !== 1'b0 || mdr_out !== 16'h1111) begin
            $display("FAIL done_idle got stall=%b rd=%b mdr=%h want 1 0 1111", mem_stall, dmem_read, mdr_out);
            n_bad++;
        end
        step(1'b1, MEM_LDW, 16'h0042, 16'h0, 1'b0, 1'b1, 16'h0042);
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_sti();
        step(1'b1, MEM_STI, 16'h4000, 16'h1357, 1'b0, 1'b0, 16'h0);
        step(1'b1, MEM_STI, 16'h4000, 16'h1357, 1'b0, 1'b1, 16'h6000);
        step(1'b1, MEM_STI, 16'h4000, 16'h1357, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if (dmem_write !== 1'b1 || dmem_address !== 16'h6000 || mdr_out !== 16'h0042) begin
            $display("FAIL rst_pre got wr=%b a=%h mdr=%h want 1 6000 0042", dmem_write, dmem_address, mdr_out);
            n_bad++;
        end
        reset = 1'b1;
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        reset = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hDEAD;
        #1;
        n_cmp++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, mem_stall, mdr_out, mdr_valid} !== 53'h0) begin
            $display("FAIL rst_mid got rd=%b wr=%b a=%h wd=%h be=%b stall=%b mdr=%h v=%b want all 0",
                     dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, mem_stall, mdr_out, mdr_valid);
            n_bad++;
        end
        step(1'b0, MEM_NONE, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++;
        if ({dmem_read, dmem_write, mem_stall, mdr_out, mdr_valid} !== 20'h0) begin
            $display("FAIL rst_late_resp got rd=%b wr=%b stall=%b mdr=%h v=%b want all 0",
                     dmem_read, dmem_write, mem_stall, mdr_out, mdr_valid);
            n_bad++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        valid_in   = 1'b0;
        mem_op_in  = MEM_NONE;
        addr_in    = '0;
        data_in    = '0;
        ext_stall  = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        test_reset();
        test_ldw();
        test_back_to_back_ldb();
        test_stb();
        test_ldi();
        test_sti();
        test_ext_stall_done();
        test_reset_mid_sti();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
